// File: rtl/cordic_result_capture.sv
// Result-capture stage behind cordic_comp: counts core iterations after a start pulse, samples the
// final x/y/z vector, flags residual convergence and presents the result on a valid/ready handshake.
module cordic_result_capture #(
  parameter int WHOLE_BIT_WIDTH   = 3,
  parameter int DECIMAL_BIT_WIDTH = 5,
  parameter int ITERATIONS        = 8,
  parameter int TOL               = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode_bit_input,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] x_in,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] y_in,
  input  logic [WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH-1:0] z_in,
  input  logic                         res_ready,
  output logic                         res_valid,
  output logic [WHOLE_BIT_WIDTH-1:0]   x_whole_out,
  output logic [DECIMAL_BIT_WIDTH-1:0] x_decimal_out,
  output logic [WHOLE_BIT_WIDTH-1:0]   y_whole_out,
  output logic [DECIMAL_BIT_WIDTH-1:0] y_decimal_out,
  output logic [WHOLE_BIT_WIDTH-1:0]   z_whole_out,
  output logic [DECIMAL_BIT_WIDTH-1:0] z_decimal_out,
  output logic                         converged,
  output logic                         busy,
  output logic                         dropped
);

  localparam int W  = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH;
  localparam int CW = $clog2(ITERATIONS) + 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(ITERATIONS - 1);
  localparam logic [W-1:0]  TOL_W    = W'(TOL);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MOST_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  z_q, z_d;
  logic          conv_q, conv_d;
  logic          valid_q, valid_d;
  logic          dropped_q, dropped_d;

  logic [W-1:0]  residual;
  logic [W-1:0]  magnitude;
  logic          conv_now;

  // The residual that should have been driven to zero depends on the mode latched with start.
  always_comb begin
    residual = mode_q ? y_in : z_in;
    if (residual == MOST_NEG) begin
      magnitude = MOST_POS;
    end else if (residual[W-1]) begin
      magnitude = W'(-residual);
    end else begin
      magnitude = residual;
    end
    conv_now = (magnitude <= TOL_W);
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can leave one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    conv_d    = conv_q;
    valid_d   = valid_q;
    dropped_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          mode_d  = mode_bit_input;
        end
      end

      RUN: begin
        if (start) begin
          cnt_d  = '0;
          mode_d = mode_bit_input;
        end else if (cnt_q == LAST_CNT) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          conv_d  = conv_now;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            mode_d  = mode_bit_input;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          dropped_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      conv_q    <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      conv_q    <= conv_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign res_valid     = valid_q;
  assign x_whole_out   = x_q[W-1:DECIMAL_BIT_WIDTH];
  assign x_decimal_out = x_q[DECIMAL_BIT_WIDTH-1:0];
  assign y_whole_out   = y_q[W-1:DECIMAL_BIT_WIDTH];
  assign y_decimal_out = y_q[DECIMAL_BIT_WIDTH-1:0];
  assign z_whole_out   = z_q[W-1:DECIMAL_BIT_WIDTH];
  assign z_decimal_out = z_q[DECIMAL_BIT_WIDTH-1:0];
  assign converged     = conv_q;
  assign busy          = (state_q != IDLE);
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_cordic_result_capture.sv
// Directed and randomized bench for cordic_result_capture, checked against an arithmetic reference
// model of the whole/decimal split and residual-convergence rules.
module tb_cordic_result_capture;

  localparam int WB  = 3;
  localparam int DB  = 5;
  localparam int IT  = 8;
  localparam int TOL = 1;
  localparam int W   = WB + DB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           mode_bit_input = 1'b0;
  logic [W-1:0]   x_in = '0;
  logic [W-1:0]   y_in = '0;
  logic [W-1:0]   z_in = '0;
  logic           res_ready = 1'b0;
  logic           res_valid;
  logic [WB-1:0]  x_whole_out, y_whole_out, z_whole_out;
  logic [DB-1:0]  x_decimal_out, y_decimal_out, z_decimal_out;
  logic           converged, busy, dropped;

  int checks = 0;
  int errors = 0;

  cordic_result_capture #(
    .WHOLE_BIT_WIDTH(WB), .DECIMAL_BIT_WIDTH(DB), .ITERATIONS(IT), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_bit_input(mode_bit_input),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .res_ready(res_ready),
    .res_valid(res_valid),
    .x_whole_out(x_whole_out), .x_decimal_out(x_decimal_out),
    .y_whole_out(y_whole_out), .y_decimal_out(y_decimal_out),
    .z_whole_out(z_whole_out), .z_decimal_out(z_decimal_out),
    .converged(converged), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Reference model: plain integer arithmetic on the unsigned code of each word.
  function automatic int whole_of(input int v);
    return v / (2 ** DB);
  endfunction

  function automatic int decimal_of(input int v);
    return v % (2 ** DB);
  endfunction

  function automatic int model_conv(input int mode, input int y, input int z);
    int r, mag;
    r = (mode != 0) ? y : z;
    if (r >= 2 ** (W - 1)) r = r - 2 ** W;
    mag = (r < 0) ? -r : r;
    if (mag > 2 ** (W - 1) - 1) mag = 2 ** (W - 1) - 1;
    return (mag <= TOL) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int mode, input int x, input int y, input int z);
    check({tag, "_valid"}, 32'(res_valid), 1);
    check({tag, "_xw"}, 32'(x_whole_out), 32'(whole_of(x)));
    check({tag, "_xd"}, 32'(x_decimal_out), 32'(decimal_of(x)));
    check({tag, "_yw"}, 32'(y_whole_out), 32'(whole_of(y)));
    check({tag, "_yd"}, 32'(y_decimal_out), 32'(decimal_of(y)));
    check({tag, "_zw"}, 32'(z_whole_out), 32'(whole_of(z)));
    check({tag, "_zd"}, 32'(z_decimal_out), 32'(decimal_of(z)));
    check({tag, "_conv"}, 32'(converged), 32'(model_conv(mode, y, z)));
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic start_job(input int mode, input int x, input int y, input int z);
    start = 1'b1;
    mode_bit_input = mode[0];
    x_in = W'(x);
    y_in = W'(y);
    z_in = W'(z);
    tick();
    start = 1'b0;
    mode_bit_input = ~mode[0];
  endtask

  // Called right after the start edge; the result must appear exactly IT edges later.
  task automatic wait_result(input string tag, input int mode, input int x, input int y, input int z);
    for (int j = 1; j < IT; j++) begin
      tick();
      check({tag, "_pending"}, 32'(res_valid), 0);
    end
    tick();
    check_result(tag, mode, x, y, z);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_hs_valid"}, 32'(res_valid), 0);
    check({tag, "_hs_busy"}, 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(res_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_dropped"}, 32'(dropped), 0);
    check({tag, "_conv"}, 32'(converged), 0);
    check({tag, "_data"}, 32'({x_whole_out, x_decimal_out, y_whole_out, y_decimal_out,
                               z_whole_out, z_decimal_out}), 0);
  endtask

  initial begin
    int mode, x, y, z, cx, cy, cz, cmode;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'(busy), 0);

    // Linear rotation example
    start_job(0, 8'b001_10000, 8'b011_00000, 8'h00);
    check("rot_busy", 32'(busy), 1);
    wait_result("rot", 0, 8'b001_10000, 8'b011_00000, 8'h00);
    check("rot_xw_literal", 32'(x_whole_out), 1);
    check("rot_conv_literal", 32'(converged), 1);
    handshake("rot");

    // Tolerance boundaries
    start_job(0, 8'h11, 8'h22, 8'hFF); wait_result("tol_ff", 0, 8'h11, 8'h22, 8'hFF); handshake("tol_ff");
    start_job(0, 8'h11, 8'h22, 8'hFE); wait_result("tol_fe", 0, 8'h11, 8'h22, 8'hFE); handshake("tol_fe");
    start_job(0, 8'h11, 8'h22, 8'h80); wait_result("tol_80", 0, 8'h11, 8'h22, 8'h80); handshake("tol_80");
    start_job(1, 8'h11, 8'h01, 8'h40); wait_result("vec_01", 1, 8'h11, 8'h01, 8'h40); handshake("vec_01");
    start_job(0, 8'h11, 8'h22, 8'h02); wait_result("tol_02", 0, 8'h11, 8'h22, 8'h02); handshake("tol_02");

    // Backpressure with a dropped start pulse
    start_job(1, 8'hA5, 8'h00, 8'h7F);
    wait_result("bp", 1, 8'hA5, 8'h00, 8'h7F);
    for (int c = 0; c < 5; c++) begin
      x_in = W'($urandom);
      y_in = W'($urandom);
      z_in = W'($urandom);
      start = (c == 2);
      mode_bit_input = 1'($urandom);
      tick();
      start = 1'b0;
      check_result("bp_hold", 1, 8'hA5, 8'h00, 8'h7F);
      check("bp_dropped", 32'(dropped), (c == 2) ? 1 : 0);
    end
    handshake("bp");

    // Handshake and restart in the same HOLD cycle
    start_job(0, 8'h3C, 8'h5A, 8'h01);
    wait_result("hsr_a", 0, 8'h3C, 8'h5A, 8'h01);
    res_ready = 1'b1;
    start = 1'b1;
    mode_bit_input = 1'b1;
    x_in = 8'hC3; y_in = 8'hFF; z_in = 8'h10;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    mode_bit_input = 1'b0;
    check("hsr_valid_drop", 32'(res_valid), 0);
    check("hsr_busy", 32'(busy), 1);
    wait_result("hsr_b", 1, 8'hC3, 8'hFF, 8'h10);
    handshake("hsr_b");

    // Restart mid-run at cnt=5; the second mode sample must win
    start_job(0, 8'h33, 8'h00, 8'h40);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("rs_pending", 32'(res_valid), 0);
    end
    start = 1'b1;
    mode_bit_input = 1'b1;
    tick();
    start = 1'b0;
    mode_bit_input = 1'b0;
    wait_result("rs", 1, 8'h33, 8'h00, 8'h40);
    handshake("rs");

    // Reset mid-run, asserted between edges at cnt=3
    start_job(0, 8'h44, 8'h55, 8'h66);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    #1 rst = 1'b0;
    for (int j = 0; j < IT + 2; j++) tick();
    check("post_reset_valid", 32'(res_valid), 0);
    check("post_reset_busy", 32'(busy), 0);

    // Randomized jobs: inputs change every cycle, the capture edge defines the result
    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 1));
      start_job(mode, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
      cmode = mode;
      if ($urandom_range(0, 4) == 0) begin
        cmode = 1 - mode;
        start = 1'b1;
        mode_bit_input = cmode[0];
        tick();
        start = 1'b0;
      end
      cx = 0; cy = 0; cz = 0;
      for (int j = 1; j <= IT; j++) begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 255));
        z = int'($urandom_range(0, 255));
        case ($urandom_range(0, 7))
          0: begin y = 0;    z = 0;    end
          1: begin y = 1;    z = 1;    end
          2: begin y = 255;  z = 255;  end
          3: begin y = 254;  z = 254;  end
          4: begin y = 128;  z = 128;  end
          5: begin y = 2;    z = 127;  end
          default: ;
        endcase
        x_in = W'(x); y_in = W'(y); z_in = W'(z);
        mode_bit_input = 1'($urandom);
        tick();
        if (j < IT) begin
          check("rnd_pending", 32'(res_valid), 0);
        end else begin
          cx = x; cy = y; cz = z;
          check_result("rnd", cmode, cx, cy, cz);
        end
      end
      repeat ($urandom_range(0, 3)) begin
        x_in = W'($urandom);
        tick();
        check_result("rnd_hold", cmode, cx, cy, cz);
      end
      handshake("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
